// File: rtl/bubble_page_loader_pkg.sv
// Shared types and constants for the page-buffer fill path: loader FSM states
// and the geometry of the 1024x1 page buffer.
package bubble_page_loader_pkg;

    localparam int ADDR_W    = 10;
    localparam int BUF_DEPTH = 1024;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BYTE = 2'd1,
        SHIFT     = 2'd2,
        FINISH    = 2'd3
    } state_e;

endpackage

// File: rtl/bubble_page_loader.sv
// Byte-stream to bit-serial page buffer loader, MSB first, all outputs registered on posedge MCLK.
// Optional byte checksum output enabled by defining PAGE_LOADER_CHECKSUM_EN.
module bubble_page_loader
    import bubble_page_loader_pkg::*;
#(
    parameter int PAGE_BITS  = 1024,
    parameter int START_ADDR = 0
) (
    input  logic              MCLK,
    input  logic              nRESET,
    input  logic              START,
    input  logic              ABORT,
    input  logic [7:0]        BYTE_IN,
    input  logic              BYTE_VALID,
    output logic              BYTE_READY,
    output logic [ADDR_W-1:0] WRADDR,
    output logic              DIN,
    output logic              nWE,
    output logic              nWRCLKEN,
    output logic              BUSY,
`ifdef PAGE_LOADER_CHECKSUM_EN
    output logic [15:0]       CHECKSUM,
`endif
    output logic              DONE
);

    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] LAST_BIT   = ADDR_W'(PAGE_BITS - 1);

    state_e            state_q;
    logic              ready_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] bitcnt_q;
    logic [7:0]        shreg_q;
    logic [ADDR_W-1:0] wraddr_q;
    logic              din_q;
    logic              nwe_q;
    logic              busy_q;
    logic              done_q;
`ifdef PAGE_LOADER_CHECKSUM_EN
    logic [15:0]       csum_q;
`endif

    // Handshake: a byte transfers on a posedge where BYTE_READY and BYTE_VALID are
    // both high; the source must hold BYTE_IN stable until that edge.
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q  <= IDLE;
            ready_q  <= 1'b0;
            addr_q   <= '0;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            wraddr_q <= '0;
            din_q    <= 1'b0;
            nwe_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef PAGE_LOADER_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            nwe_q  <= 1'b1;
            done_q <= 1'b0;
            if (ABORT && state_q != IDLE) begin
                state_q <= IDLE;
                ready_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (START) begin
                            state_q  <= WAIT_BYTE;
                            addr_q   <= FIRST_ADDR;
                            bitcnt_q <= '0;
                            busy_q   <= 1'b1;
`ifdef PAGE_LOADER_CHECKSUM_EN
                            csum_q   <= '0;
`endif
                        end
                    end
                    WAIT_BYTE: begin
                        if (ready_q && BYTE_VALID) begin
                            shreg_q <= BYTE_IN;
                            ready_q <= 1'b0;
                            state_q <= SHIFT;
`ifdef PAGE_LOADER_CHECKSUM_EN
                            csum_q  <= csum_q + {8'h00, BYTE_IN};
`endif
                        end else begin
                            ready_q <= 1'b1;
                        end
                    end
                    SHIFT: begin
                        nwe_q    <= 1'b0;
                        din_q    <= shreg_q[7];
                        wraddr_q <= addr_q;
                        shreg_q  <= {shreg_q[6:0], 1'b0};
                        addr_q   <= addr_q + ADDR_W'(1);
                        bitcnt_q <= bitcnt_q + ADDR_W'(1);
                        if (bitcnt_q == LAST_BIT) begin
                            state_q <= FINISH;
                        end else if (bitcnt_q[2:0] == 3'd7) begin
                            // Ready rises with the 8th strobe so the next byte lands 9 cycles after the last.
                            state_q <= WAIT_BYTE;
                            ready_q <= 1'b1;
                        end
                    end
                    FINISH: begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign BYTE_READY = ready_q;
    assign WRADDR     = wraddr_q;
    assign DIN        = din_q;
    assign nWE        = nwe_q;
    assign nWRCLKEN   = nwe_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;
`ifdef PAGE_LOADER_CHECKSUM_EN
    assign CHECKSUM   = csum_q;
`endif

endmodule

// File: tb/tb_bubble_page_loader.sv
// Directed bench for bubble_page_loader: two instances (16-bit page at 0, 12-bit page at 1000)
// with a write scoreboard checked on every buffer strobe.
module tb_bubble_page_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start [2];
    logic       abort [2];
    logic       valid [2];
    logic [7:0] bin   [2];
    logic       ready [2];
    logic [9:0] wraddr[2];
    logic       din   [2];
    logic       nwe   [2];
    logic       nwrclken[2];
    logic       busy  [2];
    logic       done  [2];
`ifdef PAGE_LOADER_CHECKSUM_EN
    logic [15:0] csum [2];
`endif

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          t_start = 0;
    logic [11:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bubble_page_loader #(.PAGE_BITS(16), .START_ADDR(0)) u_dut_a (
        .MCLK(clk), .nRESET(rst_n), .START(start[0]), .ABORT(abort[0]),
        .BYTE_IN(bin[0]), .BYTE_VALID(valid[0]), .BYTE_READY(ready[0]),
        .WRADDR(wraddr[0]), .DIN(din[0]), .nWE(nwe[0]), .nWRCLKEN(nwrclken[0]),
        .BUSY(busy[0]),
`ifdef PAGE_LOADER_CHECKSUM_EN
        .CHECKSUM(csum[0]),
`endif
        .DONE(done[0])
    );

    bubble_page_loader #(.PAGE_BITS(12), .START_ADDR(1000)) u_dut_b (
        .MCLK(clk), .nRESET(rst_n), .START(start[1]), .ABORT(abort[1]),
        .BYTE_IN(bin[1]), .BYTE_VALID(valid[1]), .BYTE_READY(ready[1]),
        .WRADDR(wraddr[1]), .DIN(din[1]), .nWE(nwe[1]), .nWRCLKEN(nwrclken[1]),
        .BUSY(busy[1]),
`ifdef PAGE_LOADER_CHECKSUM_EN
        .CHECKSUM(csum[1]),
`endif
        .DONE(done[1])
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs(input int s);
        return {16'h0, ready[s], wraddr[s], din[s], nwe[s], nwrclken[s], busy[s], done[s]};
    endfunction

    localparam logic [31:0] RESET_OUTS = 32'h0000_000C;

    // Every buffer strobe must match the next expected write in order.
    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (nwe[s] !== 1'b1 || nwrclken[s] !== 1'b1) begin
                check((s == 0) ? "strobe_pair_a" : "strobe_pair_b",
                      {31'h0, nwrclken[s]}, {31'h0, nwe[s]});
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $error("FAIL unexpected_strobe: observed inst %0d addr %0d din %0b expected none",
                           s, wraddr[s], din[s]);
                end else begin
                    check((s == 0) ? "write_a" : "write_b",
                          {20'h0, s[0], wraddr[s], din[s]}, {20'h0, exp_q.pop_front()});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_start(input int s);
        @(posedge clk);
        #1 start[s] = 1'b1;
        @(posedge clk);
        #1 start[s] = 1'b0;
        t_start = cyc;
    endtask

    task automatic send_byte(input int s, input logic [7:0] b, input int j,
                             input int page_bits, input int base, input bit junk);
        int w;
        bin[s]   = b;
        valid[s] = 1'b1;
        w = 0;
        while (ready[s] !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (w >= 40) begin
            check("ready_timeout", 32'd0, 32'd1);
            valid[s] = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 8; i++) begin
                if (8 * j + i < page_bits)
                    exp_q.push_back({s[0], 10'(base + 8 * j + i), b[7 - i]});
            end
            if (junk) bin[s] = 8'($urandom_range(0, 255));
            else      valid[s] = 1'b0;
        end
    endtask

    task automatic wait_done(input int s, input int exp_lat);
        int w;
        w = 0;
        while (done[s] !== 1'b1 && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (w >= 300) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            if (exp_lat >= 0) check("done_latency", 32'(cyc - t_start), 32'(exp_lat));
            check("busy_at_done", {31'h0, busy[s]}, 32'd0);
            @(negedge clk);
            check("done_one_cycle", {31'h0, done[s]}, 32'd0);
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int w;
        int seen;
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            start[s] = 1'b0; abort[s] = 1'b0; valid[s] = 1'b0; bin[s] = 8'h00;
        end
        repeat (2) @(negedge clk);
        check("reset_outs_a", outs(0), RESET_OUTS);
        check("reset_outs_b", outs(1), RESET_OUTS);
`ifdef PAGE_LOADER_CHECKSUM_EN
        check("reset_csum", {16'h0, csum[0]}, 32'd0);
`endif
        #1 rst_n = 1'b1;

        // 16-bit page, always-valid source
        do_start(0);
        @(negedge clk);
        check("ready_after_start", {30'h0, ready[0], busy[0]}, 32'b01);
        @(negedge clk);
        check("ready_next_cycle", {31'h0, ready[0]}, 32'd1);
        send_byte(0, 8'hA5, 0, 16, 0, 1'b0);
        send_byte(0, 8'h3C, 1, 16, 0, 1'b0);
        wait_done(0, 20);
`ifdef PAGE_LOADER_CHECKSUM_EN
        check("csum_a", {16'h0, csum[0]}, 32'h00E1);
`endif

        // 12-bit page at 1000, partial last byte
        do_start(1);
        send_byte(1, 8'hFF, 0, 12, 1000, 1'b0);
        send_byte(1, 8'h80, 1, 12, 1000, 1'b0);
        wait_done(1, 16);
        repeat (4) @(negedge clk);
`ifdef PAGE_LOADER_CHECKSUM_EN
        check("csum_b", {16'h0, csum[1]}, 32'h017F);
`endif

        // source stall between bytes
        do_start(0);
        send_byte(0, 8'hA5, 0, 16, 0, 1'b0);
        w = 0;
        while (ready[0] !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        check("stall_ready_rise", {31'h0, ready[0]}, 32'd1);
        repeat (5) begin
            @(negedge clk);
            check("stall_ready_no_strobe", {30'h0, ready[0], nwe[0]}, 32'b11);
        end
        send_byte(0, 8'h3C, 1, 16, 0, 1'b0);
        wait_done(0, -1);

        // abort during 3rd bit of 2nd byte, then restart
        do_start(0);
        send_byte(0, 8'hA5, 0, 16, 0, 1'b0);
        send_byte(0, 8'h3C, 1, 16, 0, 1'b0);
        w = 0;
        while (exp_q.size() > 5 && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("abort_point", 32'(exp_q.size()), 32'd5);
        abort[0] = 1'b1;
        @(posedge clk);
        #1 abort[0] = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("abort_outs", {27'h0, busy[0], ready[0], nwe[0], nwrclken[0], done[0]}, 32'b00110);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done[0] === 1'b1) seen++;
        end
        check("no_done_after_abort", 32'(seen), 32'd0);
        do_start(0);
        send_byte(0, 8'hA5, 0, 16, 0, 1'b0);
        send_byte(0, 8'h3C, 1, 16, 0, 1'b0);
        wait_done(0, 20);

        // START while busy and VALID during SHIFT are ignored
        do_start(0);
        start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        send_byte(0, 8'hA5, 0, 16, 0, 1'b1);
        send_byte(0, 8'h3C, 1, 16, 0, 1'b1);
        start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        wait_done(0, 20);
        valid[0] = 1'b0;
`ifdef PAGE_LOADER_CHECKSUM_EN
        check("csum_disturbed", {16'h0, csum[0]}, 32'h00E1);
`endif

        // asynchronous reset mid-SHIFT
        do_start(0);
        send_byte(0, 8'hA5, 0, 16, 0, 1'b0);
        w = 0;
        while (nwe[0] !== 1'b0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outs", outs(0), RESET_OUTS);
        exp_q.delete();
        @(negedge clk);
        check("reset_no_strobe", {30'h0, nwe[0], nwrclken[0]}, 32'b11);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_idle", outs(0), RESET_OUTS);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
